// File: rtl/fetch_unit_assoc.sv
// Instruction fetch stage with an N-way set-associative L1 I-cache: one-cycle
// hit pipeline, blocking miss FSM with in-place replay, round-robin fill, flush.
//
// state | meaning
// IDLE  | S1 lookups flow; new fetches accepted while S1 is empty or hits
// MISS  | line request outstanding; S1 frozen until the matching refill lands
module fetch_unit_assoc #(
  parameter int ADDR_W     = 64,
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 256,
  parameter int WAYS       = 2,
  parameter int INSTR_W    = 32
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    flushPipeline_i,
  input  logic                    fetchEnable_i,
  input  logic [ADDR_W-1:0]       fetchAddr_i,
  output logic                    fetchReady_o,
  input  logic                    refillValid_i,
  input  logic [ADDR_W-1:0]       refillAddr_i,
  input  logic [LINE_BYTES*8-1:0] refillLine_i,
  output logic                    instrValid_o,
  output logic [INSTR_W-1:0]      instr_o,
  output logic [ADDR_W-1:0]       instrAddr_o,
  output logic                    missValid_o,
  output logic [ADDR_W-1:0]       missAddr_o
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WORDS  = LINE_W / INSTR_W;
  localparam int WSEL_W = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} fsmState_t;

  fsmState_t stateQ, stateD;

  logic                s1Valid;
  logic [ADDR_W-1:0]   s1Addr;
  logic                runQ;
  logic                instrValidQ;
  logic [INSTR_W-1:0]  instrQ;
  logic [ADDR_W-1:0]   instrAddrQ;
  logic [ADDR_W-1:0]   missAddrQ;

  logic [IDX_W-1:0]    s1Idx, rIdx;
  logic [TAG_W-1:0]    s1Tag, rTag;
  logic [WAYS-1:0]     lkHit, rfMatch, rfValid, wrEn;
  logic [LINE_W-1:0]   lkLine [WAYS];
  logic [LINE_W-1:0]   hitLine;
  logic [WSEL_W-1:0]   wordIdx;
  logic [INSTR_W-1:0]  instrSel;
  logic                s1Hit, s1Miss, refillHit;

  logic [SETS-1:0][PTR_W-1:0] rrPtr;
  logic [PTR_W-1:0]    curPtr, ptrNext, matchWay, freeWay, fillWay;
  logic                anyMatch, anyFree;
  logic                unusedRefillOff;

  assign s1Idx = s1Addr[OFF_W +: IDX_W];
  assign s1Tag = s1Addr[ADDR_W-1 -: TAG_W];
  assign rIdx  = refillAddr_i[OFF_W +: IDX_W];
  assign rTag  = refillAddr_i[ADDR_W-1 -: TAG_W];
  assign unusedRefillOff = ^refillAddr_i[OFF_W-1:0];

  // Per-way storage: valid bits reset, tags and lines are plain memories.
  for (genvar g = 0; g < WAYS; g++) begin : gWay
    logic [SETS-1:0]   validQ;
    logic [TAG_W-1:0]  tagMem  [SETS];
    logic [LINE_W-1:0] lineMem [SETS];

    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        validQ <= '0;
      end else if (wrEn[g]) begin
        validQ[rIdx] <= 1'b1;
      end
    end

    always_ff @(posedge clock_i) begin
      if (wrEn[g]) begin
        tagMem[rIdx]  <= rTag;
        lineMem[rIdx] <= refillLine_i;
      end
    end

    assign lkHit[g]   = validQ[s1Idx] && (tagMem[s1Idx] == s1Tag);
    assign lkLine[g]  = lineMem[s1Idx];
    assign rfValid[g] = validQ[rIdx];
    assign rfMatch[g] = validQ[rIdx] && (tagMem[rIdx] == rTag);
    assign wrEn[g]    = refillValid_i && (fillWay == PTR_W'(g));
  end

  always_comb begin
    hitLine = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (lkHit[w[PTR_W-1:0]]) hitLine = lkLine[w[PTR_W-1:0]];
    end
  end

  if (OFF_W > 2) begin : gWordIdx
    assign wordIdx = s1Addr[OFF_W-1:2];
  end else begin : gWordIdxNone
    assign wordIdx = '0;
  end

  // Word 0 sits in the most significant bits of the line.
  always_comb begin
    instrSel = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (WSEL_W'(w) == wordIdx) instrSel = hitLine[(WORDS-1-w)*INSTR_W +: INSTR_W];
    end
  end

  assign s1Hit     = s1Valid && (|lkHit);
  assign s1Miss    = s1Valid && !(|lkHit);
  assign refillHit = refillValid_i &&
                     (refillAddr_i[ADDR_W-1:OFF_W] == missAddrQ[ADDR_W-1:OFF_W]);

  // Fill victim: way already holding the tag, else lowest invalid, else pointer.
  always_comb begin
    anyMatch = 1'b0;
    anyFree  = 1'b0;
    matchWay = '0;
    freeWay  = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (rfMatch[w[PTR_W-1:0]]) begin
        anyMatch = 1'b1;
        matchWay = w[PTR_W-1:0];
      end
      if (!rfValid[w[PTR_W-1:0]]) begin
        anyFree = 1'b1;
        freeWay = w[PTR_W-1:0];
      end
    end
    curPtr  = rrPtr[rIdx];
    ptrNext = (WAYS > 1) ? curPtr + PTR_W'(1) : '0;
    if (anyMatch)     fillWay = matchWay;
    else if (anyFree) fillWay = freeWay;
    else              fillWay = curPtr;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rrPtr <= '0;
    end else if (refillValid_i && !anyMatch) begin
      rrPtr[rIdx] <= ptrNext;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) stateQ <= IDLE;
    else         stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    if (flushPipeline_i) begin
      stateD = IDLE;
    end else begin
      case (stateQ)
        IDLE:    if (s1Miss)    stateD = MISS;
        MISS:    if (refillHit) stateD = IDLE;
        default: stateD = IDLE;
      endcase
    end
  end

  always_comb begin
    missValid_o  = (stateQ == MISS);
    fetchReady_o = runQ && (stateQ == IDLE) && !s1Miss;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      runQ        <= 1'b0;
      s1Valid     <= 1'b0;
      s1Addr      <= '0;
      instrValidQ <= 1'b0;
      instrQ      <= '0;
      instrAddrQ  <= '0;
      missAddrQ   <= '0;
    end else begin
      runQ        <= 1'b1;
      instrValidQ <= 1'b0;
      if (flushPipeline_i) begin
        s1Valid <= 1'b0;
      end else begin
        if ((stateQ == IDLE) && s1Hit) begin
          instrValidQ <= 1'b1;
          instrQ      <= instrSel;
          instrAddrQ  <= s1Addr;
        end
        if ((stateQ == IDLE) && s1Miss) begin
          missAddrQ <= {s1Addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        end
        // S1 only moves when ready; otherwise it holds the missing fetch for replay.
        if (fetchReady_o) begin
          s1Valid <= fetchEnable_i;
          if (fetchEnable_i) s1Addr <= fetchAddr_i;
        end
      end
    end
  end

  assign instrValid_o = instrValidQ;
  assign instr_o      = instrQ;
  assign instrAddr_o  = instrAddrQ;
  assign missAddr_o   = missAddrQ;

endmodule

// File: tb/tb_fetch_unit_assoc.sv
// Scenario bench for fetch_unit_assoc: expected instructions are queued when a
// fetch is driven and popped by a negedge monitor when instrValid_o fires.
module tb_fetch_unit_assoc;

  localparam logic [255:0] LINE_A = 256'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         fetchEn = 1'b0;
  logic [63:0]  fetchAddr = '0;
  logic         refillValid = 1'b0;
  logic [63:0]  refillAddr = '0;
  logic [255:0] refillLine = '0;
  logic         fetchReady, instrValid, missValid;
  logic [31:0]  instr;
  logic [63:0]  instrAddr, missAddr;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
  } expItem_t;

  expItem_t expQ[$];
  expItem_t e;
  int total = 0;
  int bad = 0;

  fetch_unit_assoc dut (
    .clock_i(clk),
    .reset_i(rst),
    .flushPipeline_i(flush),
    .fetchEnable_i(fetchEn),
    .fetchAddr_i(fetchAddr),
    .fetchReady_o(fetchReady),
    .refillValid_i(refillValid),
    .refillAddr_i(refillAddr),
    .refillLine_i(refillLine),
    .instrValid_o(instrValid),
    .instr_o(instr),
    .instrAddr_o(instrAddr),
    .missValid_o(missValid),
    .missAddr_o(missAddr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && instrValid) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("FAIL unexpected_instr got=%h@%h want=none", instr, instrAddr);
      end else begin
        e = expQ.pop_front();
        if (instr !== e.instr || instrAddr !== e.addr) begin
          bad++;
          $display("FAIL instr_out got=%h@%h want=%h@%h", instr, instrAddr, e.instr, e.addr);
        end
      end
    end
  end

  function automatic logic [255:0] mkLine(input logic [31:0] seed);
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[(7-i)*32 +: 32] = seed + 32'(i);
    return l;
  endfunction

  function automatic logic [31:0] wordOf(input logic [255:0] line, input logic [63:0] addr);
    int wi;
    wi = int'(addr[4:2]);
    return line[(7-wi)*32 +: 32];
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; flush = 1'b0; fetchEn = 1'b0; refillValid = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    expQ.delete();
  endtask

  task automatic refillOne(input logic [63:0] a, input logic [255:0] l);
    refillValid = 1'b1; refillAddr = a; refillLine = l;
    tick(1);
    refillValid = 1'b0;
  endtask

  task automatic driveFetch(input logic [63:0] a, input logic [255:0] l, input bit expectHit);
    expItem_t it;
    fetchEn = 1'b1; fetchAddr = a;
    if (expectHit) begin
      it.instr = wordOf(l, a);
      it.addr  = a;
      expQ.push_back(it);
    end
    tick(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    total++; if (fetchReady !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", fetchReady); end
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL rst_ivalid got=%b want=0", instrValid); end
    total++; if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instr); end
    total++; if (instrAddr !== 64'h0) begin bad++; $display("FAIL rst_iaddr got=%h want=0", instrAddr); end
    total++; if (missValid !== 1'b0) begin bad++; $display("FAIL rst_mvalid got=%b want=0", missValid); end
    total++; if (missAddr !== 64'h0) begin bad++; $display("FAIL rst_maddr got=%h want=0", missAddr); end
    rst = 1'b0;
    tick(1);
    total++; if (fetchReady !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", fetchReady); end
  endtask

  task automatic test_miss();
    driveFetch(64'hA104, LINE_A, 1'b0);
    fetchEn = 1'b0;
    total++; if (fetchReady !== 1'b0) begin bad++; $display("FAIL miss_ready_drop got=%b want=0", fetchReady); end
    tick(1);
    total++; if (missValid !== 1'b1) begin bad++; $display("FAIL miss_valid got=%b want=1", missValid); end
    total++; if (missAddr !== 64'hA100) begin bad++; $display("FAIL miss_addr got=%h want=a100", missAddr); end
    total++; if (fetchReady !== 1'b0) begin bad++; $display("FAIL miss_ready got=%b want=0", fetchReady); end
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL miss_ivalid got=%b want=0", instrValid); end
    tick(2);
    total++; if (missValid !== 1'b1 || missAddr !== 64'hA100) begin bad++; $display("FAIL miss_stable got=%b/%h want=1/a100", missValid, missAddr); end
  endtask

  task automatic test_refill();
    expItem_t it;
    refillOne(64'hB100, mkLine(32'hB0000000));
    total++; if (missValid !== 1'b1) begin bad++; $display("FAIL refill_prefetch_keeps_miss got=%b want=1", missValid); end
    it.instr = 32'hEEEEEEEE;
    it.addr  = 64'hA104;
    expQ.push_back(it);
    refillOne(64'hA100, LINE_A);
    total++; if (missValid !== 1'b0) begin bad++; $display("FAIL refill_miss_drop got=%b want=0", missValid); end
    tick(3);
    total++; if (expQ.size() !== 0) begin bad++; $display("FAIL refill_replay got=%0d pending want=0", expQ.size()); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      total++; if (fetchReady !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got=%b want=1", i, fetchReady); end
      driveFetch(64'hA100 + 64'(4*i), LINE_A, 1'b1);
    end
    fetchEn = 1'b0;
    total++; if (missValid !== 1'b0) begin bad++; $display("FAIL stream_nomiss got=%b want=0", missValid); end
    tick(3);
    total++; if (expQ.size() !== 0) begin bad++; $display("FAIL stream_drain got=%0d pending want=0", expQ.size()); end
  endtask

  task automatic test_replace();
    logic [255:0] lineC, lineC2, lineE, lineX;
    lineC  = mkLine(32'hC0000000);
    lineC2 = mkLine(32'hC2000000);
    lineE  = mkLine(32'hE0000000);
    lineX  = mkLine(32'h10000000);
    doReset();
    refillOne(64'hA100, LINE_A);
    refillOne(64'hC100, lineC);
    refillOne(64'hE100, lineE);
    total++; if (missValid !== 1'b0) begin bad++; $display("FAIL repl_prefetch got=%b want=0", missValid); end
    driveFetch(64'hC100, lineC, 1'b1);
    driveFetch(64'hE104, lineE, 1'b1);
    fetchEn = 1'b0;
    tick(3);
    total++; if (expQ.size() !== 0 || missValid !== 1'b0) begin bad++; $display("FAIL repl_hits got=%0d/%b want=0/0", expQ.size(), missValid); end
    driveFetch(64'hA100, LINE_A, 1'b0);
    fetchEn = 1'b0;
    tick(1);
    total++; if (missValid !== 1'b1 || missAddr !== 64'hA100) begin bad++; $display("FAIL repl_evicted got=%b/%h want=1/a100", missValid, missAddr); end
    flush = 1'b1; tick(1); flush = 1'b0;
    refillOne(64'hC100, lineC2);
    driveFetch(64'hC104, lineC2, 1'b1);
    fetchEn = 1'b0;
    tick(3);
    total++; if (expQ.size() !== 0 || missValid !== 1'b0) begin bad++; $display("FAIL repl_overwrite got=%0d/%b want=0/0", expQ.size(), missValid); end
    refillOne(64'h10100, lineX);
    driveFetch(64'hE100, lineE, 1'b1);
    driveFetch(64'h10108, lineX, 1'b1);
    driveFetch(64'hC104, lineC2, 1'b0);
    fetchEn = 1'b0;
    tick(1);
    total++; if (missValid !== 1'b1 || missAddr !== 64'hC100) begin bad++; $display("FAIL repl_ptr_kept got=%b/%h want=1/c100", missValid, missAddr); end
    total++; if (expQ.size() !== 0) begin bad++; $display("FAIL repl_survivors got=%0d pending want=0", expQ.size()); end
    flush = 1'b1; tick(1); flush = 1'b0;
  endtask

  task automatic test_flush();
    doReset();
    driveFetch(64'hA104, LINE_A, 1'b0);
    fetchEn = 1'b0;
    tick(1);
    total++; if (missValid !== 1'b1) begin bad++; $display("FAIL flush_pre_miss got=%b want=1", missValid); end
    flush = 1'b1; tick(1); flush = 1'b0;
    total++; if (missValid !== 1'b0) begin bad++; $display("FAIL flush_mvalid got=%b want=0", missValid); end
    total++; if (fetchReady !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", fetchReady); end
    tick(3);
    total++; if (missValid !== 1'b0) begin bad++; $display("FAIL flush_no_rerequest got=%b want=0", missValid); end
    refillOne(64'hA100, LINE_A);
    driveFetch(64'hA108, LINE_A, 1'b1);
    fetchEn = 1'b0;
    tick(3);
    total++; if (expQ.size() !== 0) begin bad++; $display("FAIL flush_refetch got=%0d pending want=0", expQ.size()); end
    fetchEn = 1'b1; fetchAddr = 64'hA10C; flush = 1'b1;
    tick(1);
    fetchEn = 1'b0; flush = 1'b0;
    tick(1);
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL flush_drop got=%b want=0", instrValid); end
    driveFetch(64'hA110, LINE_A, 1'b0);
    fetchEn = 1'b0; flush = 1'b1;
    tick(1);
    flush = 1'b0;
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL flush_kill got=%b want=0", instrValid); end
    flush = 1'b1;
    refillOne(64'hE100, mkLine(32'hE0000000));
    flush = 1'b0;
    driveFetch(64'hE104, mkLine(32'hE0000000), 1'b1);
    fetchEn = 1'b0;
    tick(3);
    total++; if (expQ.size() !== 0 || missValid !== 1'b0) begin bad++; $display("FAIL flush_refill_kept got=%0d/%b want=0/0", expQ.size(), missValid); end
  endtask

  task automatic test_reset_miss();
    doReset();
    refillOne(64'hA100, LINE_A);
    driveFetch(64'hA100, LINE_A, 1'b1);
    fetchEn = 1'b0;
    tick(3);
    total++; if (expQ.size() !== 0) begin bad++; $display("FAIL rmiss_prefill got=%0d pending want=0", expQ.size()); end
    driveFetch(64'hC104, LINE_A, 1'b0);
    fetchEn = 1'b0;
    tick(1);
    total++; if (missValid !== 1'b1) begin bad++; $display("FAIL rmiss_pre got=%b want=1", missValid); end
    rst = 1'b1;
    tick(2);
    total++; if ({fetchReady, instrValid, missValid} !== 3'b000) begin bad++; $display("FAIL rmiss_flags got=%b want=000", {fetchReady, instrValid, missValid}); end
    total++; if (instr !== 32'h0 || instrAddr !== 64'h0) begin bad++; $display("FAIL rmiss_instr got=%h@%h want=0@0", instr, instrAddr); end
    total++; if (missAddr !== 64'h0) begin bad++; $display("FAIL rmiss_maddr got=%h want=0", missAddr); end
    rst = 1'b0;
    tick(1);
    driveFetch(64'hA100, LINE_A, 1'b0);
    fetchEn = 1'b0;
    tick(1);
    total++; if (missValid !== 1'b1 || missAddr !== 64'hA100) begin bad++; $display("FAIL rmiss_invalidated got=%b/%h want=1/a100", missValid, missAddr); end
    total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL rmiss_no_hit got=%b want=0", instrValid); end
    doReset();
  endtask

  initial begin
    test_reset();
    test_miss();
    test_refill();
    test_stream();
    test_replace();
    test_flush();
    test_reset_miss();
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
